// File: rtl/arb_rr_mux_pkg.sv
// arb_rr_mux_pkg: shared state type and pointer helper for the round-robin arbiter mux
package arb_rr_mux_pkg;

    typedef enum logic {IDLE, LOCK} arb_sta_t;

    localparam int MAXW = 64;

    // rotate the low w bits of v left by one, bit w-1 wrapping to bit 0
    function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] m;
        m = (MAXW'(1) << w) - MAXW'(1);
        rotl1 = (((v & m) << 1) | ((v & m) >> (w - 1))) & m;
    endfunction

endpackage

// File: rtl/arb_rr_oht.sv
// arb_rr_oht: combinational round-robin one-hot priority encoder
module arb_rr_oht #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] win
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] iso;

    // low half keeps requests at or above the pointer, high half the full set so the search wraps
    always_comb begin
        dbl = {req, req & ~(ptr - WIDTH'(1))};
        iso = dbl & (~dbl + (2*WIDTH)'(1));
        win = iso[WIDTH-1:0] | iso[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/mux_oht.sv
// mux_oht: one-hot selected multiplexer built as a SPLIT-ary OR tree
module mux_oht #(
    parameter type DAT_T = logic [8-1:0],
    parameter int WIDTH = 4,
    parameter int SPLIT = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] oht,
    input  DAT_T             ary [0:WIDTH-1],
    output DAT_T             dat
);

    function automatic int levels(input int w, input int s);
        int n = 1;
        levels = 0;
        while (n < w) begin
            n *= s;
            levels++;
        end
    endfunction

    localparam int DW = $bits(DAT_T);
    localparam int LVL = levels(WIDTH, SPLIT);
    localparam int LEAF = SPLIT ** LVL;

    logic [DW-1:0] node [0:LVL][0:LEAF-1];

    // mask each leaf by its select bit, then fold groups of SPLIT nodes upward level by level
    always_comb begin
        for (int l = 0; l <= LVL; l++)
            for (int n = 0; n < LEAF; n++)
                node[l][n] = '0;
        for (int n = 0; n < WIDTH; n++)
            node[0][n] = (IMPLEMENTATION == 0) ? (oht[n] ? DW'(ary[n]) : '0) : (DW'(ary[n]) & {DW{oht[n]}});
        for (int l = 0; l < LVL; l++)
            for (int n = 0; n < LEAF; n++)
                node[l + 1][n / SPLIT] = node[l + 1][n / SPLIT] | node[l][n];
    end

    assign dat = DAT_T'(node[LVL][0]);

endmodule

// File: rtl/arb_rr_mux.sv
// arb_rr_mux: round-robin arbiter with packet locking feeding one registered output stage
module arb_rr_mux
    import arb_rr_mux_pkg::*;
#(
    parameter type DAT_T = logic [8-1:0],
    parameter int WIDTH = 4,
    parameter int SPLIT = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_vld,
    input  logic [WIDTH-1:0] req_lst,
    input  DAT_T             req_dat [0:WIDTH-1],
    output logic [WIDTH-1:0] req_rdy,
    output logic [WIDTH-1:0] gnt,
    output logic             out_vld,
    output logic             out_lst,
    output DAT_T             out_dat,
    input  logic             out_rdy
);

    arb_sta_t         sta, sta_nxt;
    logic [WIDTH-1:0] ptr, ptr_nxt;
    logic [WIDTH-1:0] own, own_nxt;
    logic [WIDTH-1:0] rr_win;
    logic             ld;
    logic             sel_lst;
    DAT_T             sel_dat;

    arb_rr_oht #(.WIDTH(WIDTH)) u_oht (
        .req(req_vld),
        .ptr(ptr),
        .win(rr_win)
    );

    mux_oht #(
        .DAT_T(DAT_T),
        .WIDTH(WIDTH),
        .SPLIT(SPLIT),
        .IMPLEMENTATION(IMPLEMENTATION)
    ) u_mux (
        .oht(gnt),
        .ary(req_dat),
        .dat(sel_dat)
    );

    // a locked owner is offered ready even when idle; nothing is offered while reset is held
    always_comb begin
        ld = ~out_vld | out_rdy;
        req_rdy = (ld & ~rst) ? ((sta == LOCK) ? own : rr_win) : '0;
        gnt = req_rdy & req_vld;
        sel_lst = |(gnt & req_lst);
    end

    // only a transfer moves state; a last beat releases the lock and rotates priority past the winner
    always_comb begin
        sta_nxt = sta;
        own_nxt = own;
        ptr_nxt = ptr;
        if (|gnt) begin
            sta_nxt = sel_lst ? IDLE : LOCK;
            own_nxt = sel_lst ? '0 : gnt;
            ptr_nxt = sel_lst ? WIDTH'(rotl1(MAXW'(gnt), WIDTH)) : ptr;
        end
    end

    // arbitration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sta <= IDLE;
            own <= '0;
            ptr <= WIDTH'(1);
        end else begin
            sta <= sta_nxt;
            own <= own_nxt;
            ptr <= ptr_nxt;
        end
    end

    // output stage: refills whenever empty or draining, payload held across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_lst <= 1'b0;
            out_dat <= '0;
        end else if (ld) begin
            out_vld <= |gnt;
            if (|gnt) begin
                out_dat <= sel_dat;
                out_lst <= sel_lst;
            end
        end
    end

endmodule
